cpu_control_unit: RTL and testbench

Multi-cycle control FSM that drives the CPU datapath: it issues instruction fetches, decodes the 3-bit opcode returned by the datapath, and sequences ALU, memory and register-write control signals. It owns the program counter and resolves BEQ branches using the datapath's BEQ flag and newPC target. It waits on the memory handshake (memDone) and reports a halt/fault status to top level.

---
 rtl/cpu_control_unit_if.sv | 38 +++
 rtl/cpu_control_unit.sv | 170 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle.
// master: control unit side; slave: datapath/memory side.
// Optional macro CTRL_PERF_COUNT_EN adds the retired-instruction counter.
interface cpu_control_unit_if #(
  parameter int unsigned PC_WIDTH = 13
);
  logic [2:0]          Opcode;
  logic                BEQ;
  logic [PC_WIDTH-1:0] newPC;
  logic                memDone;
  logic                read;
  logic                write;
  logic                instruction;
  logic                instructionType;
  logic [2:0]          ALU_Op;
  logic                writeFlag;
  logic [PC_WIDTH-1:0] PC;
  logic                halted;
`ifdef CTRL_PERF_COUNT_EN
  logic [15:0]         retired;
`endif

  modport master (
    input  Opcode, BEQ, newPC, memDone,
    output read, write, instruction, instructionType, ALU_Op, writeFlag, PC, halted
`ifdef CTRL_PERF_COUNT_EN
    , output retired
`endif
  );

  modport slave (
    output Opcode, BEQ, newPC, memDone,
    input  read, write, instruction, instructionType, ALU_Op, writeFlag, PC, halted
`ifdef CTRL_PERF_COUNT_EN
    , input retired
`endif
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU control FSM: fetch, decode, execute, memory, writeback.
// Owns the PC, resolves BEQ, watches memDone with a timeout into a sticky fault.
// Optional macro CTRL_PERF_COUNT_EN adds a 16-bit retired-instruction counter.
module cpu_control_unit #(
  parameter int unsigned PC_WIDTH    = 13,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  cpu_control_unit_if.master bus
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]          op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                started_q;
  logic                retire;

  logic                rd, wr, instr, itype, wf, halt;
  logic [2:0]          alu;
  logic [2:0]          alu_dec;
  logic                itype_dec;

  // Opcode-derived ALU operation and operand-2 select
  always_comb begin
    alu_dec   = 3'b000;
    itype_dec = 1'b0;
    case (op_q)
      3'b001, 3'b111: alu_dec = 3'b001;
      3'b010:         alu_dec = 3'b010;
      3'b011:         alu_dec = 3'b011;
      default:        alu_dec = 3'b000;
    endcase
    itype_dec = ~op_q[2] | (op_q == 3'b111);
  end

  // State, PC, opcode latch and timeout counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_WIDTH'(RESET_PC);
      op_q      <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
    end
  end

  // Next-state, PC update and control outputs
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    instr   = 1'b1;
    itype   = 1'b0;
    alu     = 3'b000;
    wf      = 1'b0;
    halt    = 1'b0;
    case (state_q)
      // started_q keeps read low in the first cycle after reset release
      S_FETCH: begin
        if (started_q) begin
          rd = 1'b1;
          if (bus.memDone) begin
            state_d = S_DECODE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DECODE: begin
        op_d    = bus.Opcode;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu   = alu_dec;
        itype = itype_dec;
        if (op_q == 3'b101 || op_q == 3'b110) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else if (op_q == 3'b111) begin
          pc_d    = bus.BEQ ? bus.newPC : pc_q + PC_WIDTH'(1);
          state_d = S_FETCH;
          cnt_d   = '0;
          retire  = 1'b1;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        instr = 1'b0;
        alu   = alu_dec;
        itype = itype_dec;
        if (op_q == 3'b101) rd = 1'b1;
        else                wr = 1'b1;
        if (bus.memDone) begin
          cnt_d = '0;
          if (op_q == 3'b101) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITEBACK: begin
        wf      = 1'b1;
        alu     = alu_dec;
        itype   = itype_dec;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_FETCH;
        cnt_d   = '0;
        retire  = 1'b1;
      end
      S_FAULT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign bus.read            = rd;
  assign bus.write           = wr;
  assign bus.instruction     = instr;
  assign bus.instructionType = itype;
  assign bus.ALU_Op          = alu;
  assign bus.writeFlag       = wf;
  assign bus.PC              = pc_q;
  assign bus.halted          = halt;

`ifdef CTRL_PERF_COUNT_EN
  logic [15:0] retired_q;

  // Retired-instruction counter, wraps at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 16'd1;
  end

  assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: expectations are queued when an
// instruction is issued and compared when the DUT starts the next fetch.
module tb_cpu_control_unit;
  localparam int unsigned PW = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_control_unit_if #(.PC_WIDTH(PW)) bus ();

  cpu_control_unit #(
    .PC_WIDTH   (PW),
    .RESET_PC   (0),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cycles;
    int unsigned fcyc;
    int unsigned mrd;
    int unsigned mwr;
    int unsigned wf;
    logic [2:0]  alu;
    logic        it;
    logic [PW-1:0] pc;
  } exp_t;

  exp_t sb[$];

  logic [PW-1:0] m_pc;
  logic [15:0]   m_ret;

  logic s_rd, s_wr, s_ins, s_it, s_wf, s_halt;
  logic [2:0] s_alu;
  logic [PW-1:0] s_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    s_rd   = bus.read;
    s_wr   = bus.write;
    s_ins  = bus.instruction;
    s_it   = bus.instructionType;
    s_alu  = bus.ALU_Op;
    s_wf   = bus.writeFlag;
    s_pc   = bus.PC;
    s_halt = bus.halted;
  endtask

  // Issue one instruction; the current sample must be its first fetch cycle.
  task automatic run_instr(input logic [2:0] op, input logic beq, input logic [PW-1:0] npc,
                           input int unsigned fw, input int unsigned mw, input bit noise);
    exp_t e, g;
    bit is_mem;
    bit done = 0;
    bit md;
    int unsigned total = 0, fc = 0, mrd = 0, mwr = 0, wfc = 0, nf = 0, viol = 0, hold_bad = 0;
    logic [2:0] alu_c = 3'b000;
    logic it_c = 1'b0;

    is_mem   = (op == 3'd5) || (op == 3'd6);
    e.fcyc   = fw + 1;
    e.mrd    = (op == 3'd5) ? mw + 1 : 0;
    e.mwr    = (op == 3'd6) ? mw + 1 : 0;
    e.wf     = (op == 3'd6 || op == 3'd7) ? 0 : 1;
    case (op)
      3'd1, 3'd7: e.alu = 3'b001;
      3'd2:       e.alu = 3'b010;
      3'd3:       e.alu = 3'b011;
      default:    e.alu = 3'b000;
    endcase
    e.it     = (op <= 3'd3) || (op == 3'd7);
    e.cycles = ((op == 3'd7) ? 3 : (op == 3'd5) ? 5 : 4) + fw + (is_mem ? mw : 0);
    if (op == 3'd7 && beq) m_pc = npc;
    else                   m_pc = m_pc + 1'b1;
    e.pc  = m_pc;
    m_ret = m_ret + 16'd1;
    sb.push_back(e);

    bus.Opcode = op;
    bus.BEQ    = beq;
    bus.newPC  = npc;

    for (int k = 0; k < 200 && !done; k++) begin
      if (k > 0) sample();
      if (k > 0 && s_rd && s_ins && nf > 0) begin
        done  = 1;
        total = k;
        bus.memDone = 1'b0;
      end else begin
        if (s_rd && s_wr) viol++;
        if (s_wf && (s_rd || s_wr)) viol++;
        if (s_wf) wfc++;
        if (s_rd && s_ins) begin
          fc++;
          md = (fc == fw + 1);
        end else begin
          nf++;
          if (nf == 2) begin
            alu_c = s_alu;
            it_c  = s_it;
          end else if (nf > 2 && (s_alu != alu_c || s_it != it_c)) begin
            hold_bad++;
          end
          if (!s_ins && (s_rd || s_wr)) begin
            if (s_rd) mrd++;
            else      mwr++;
            md = ((mrd + mwr) == mw + 1);
          end else begin
            md = noise;
          end
        end
        bus.memDone = md;
      end
    end

    check_eq("complete", 32'(done), 32'd1);
    g = sb.pop_front();
    check_eq("cycles", total, g.cycles);
    check_eq("fetch_cycles", fc, g.fcyc);
    check_eq("mem_read_cycles", mrd, g.mrd);
    check_eq("mem_write_cycles", mwr, g.mwr);
    check_eq("writeFlag_cycles", wfc, g.wf);
    check_eq("alu_op", 32'(alu_c), 32'(g.alu));
    check_eq("instr_type", 32'(it_c), 32'(g.it));
    check_eq("alu_hold", hold_bad, 0);
    check_eq("excl_violations", viol, 0);
    check_eq("pc", 32'(s_pc), 32'(g.pc));
`ifdef CTRL_PERF_COUNT_EN
    check_eq("retired", 32'(bus.retired), 32'(m_ret));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_read"},  32'(bus.read), 32'd0);
    check_eq({tag, "_write"}, 32'(bus.write), 32'd0);
    check_eq({tag, "_wf"},    32'(bus.writeFlag), 32'd0);
    check_eq({tag, "_it"},    32'(bus.instructionType), 32'd0);
    check_eq({tag, "_instr"}, 32'(bus.instruction), 32'd1);
    check_eq({tag, "_alu"},   32'(bus.ALU_Op), 32'd0);
    check_eq({tag, "_pc"},    32'(bus.PC), 32'd0);
    check_eq({tag, "_halt"},  32'(bus.halted), 32'd0);
`ifdef CTRL_PERF_COUNT_EN
    check_eq({tag, "_retired"}, 32'(bus.retired), 32'd0);
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.memDone = 1'b0;
    m_pc  = '0;
    m_ret = '0;
    sample();
    check_eq("post_reset_fetch", 32'({s_rd, s_ins}), 32'd3);
  endtask

  task automatic run_fault();
    int unsigned rc = 0;
    bit seen = 0;
    bus.Opcode = 3'd0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (k > 0) sample();
      if (s_halt) seen = 1;
      else begin
        if (s_rd) rc++;
        bus.memDone = 1'b0;
      end
    end
    check_eq("fault_halted", 32'(seen), 32'd1);
    check_eq("fault_wait_cycles", rc, 15);
    check_eq("fault_read", 32'(s_rd), 32'd0);
    check_eq("fault_pc", 32'(s_pc), 32'(m_pc));
    bus.memDone = 1'b1;
    repeat (3) sample();
    check_eq("fault_sticky", 32'(s_halt), 32'd1);
    check_eq("fault_pc_frozen", 32'(s_pc), 32'(m_pc));
    check_eq("fault_quiet", 32'({s_rd, s_wr, s_wf}), 32'd0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("fault_reset");
    release_reset();
  endtask

  task automatic run_mid_mem_reset();
    bit seen = 0;
    bus.Opcode = 3'd6;
    bus.memDone = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k > 0) sample();
      if (s_wr && !s_ins) seen = 1;
      else bus.memDone = (s_rd && s_ins);
    end
    bus.memDone = 1'b0;
    check_eq("midmem_write_seen", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midmem_reset");
    @(posedge clk);
    #1 check_eq("midmem_wf_in_reset", 32'(bus.writeFlag | bus.write), 32'd0);
    release_reset();
  endtask

  initial begin
    reset       = 1'b0;
    bus.Opcode  = 3'd0;
    bus.BEQ     = 1'b0;
    bus.newPC   = '0;
    bus.memDone = 1'b0;
    m_pc  = '0;
    m_ret = '0;
    @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    run_instr(3'd0, 1'b0, '0, 0, 0, 0);          // ADD, zero wait
    run_instr(3'd1, 1'b0, '0, 2, 0, 1);          // SUB with stray memDone
    run_instr(3'd2, 1'b0, '0, 1, 0, 1);          // AND
    run_instr(3'd3, 1'b0, '0, 0, 0, 0);          // OR
    run_instr(3'd4, 1'b0, '0, 0, 0, 1);          // ADDI
    run_instr(3'd7, 1'b1, 13'h0040, 0, 0, 0);    // BEQ taken
    run_instr(3'd7, 1'b0, 13'h1234, 0, 0, 1);    // BEQ not taken
    run_instr(3'd5, 1'b0, '0, 0, 3, 0);          // LD, 3 wait cycles
    run_instr(3'd5, 1'b0, '0, 14, 14, 1);        // LD at timeout edge
    run_instr(3'd6, 1'b0, '0, 0, 0, 0);          // ST
    run_instr(3'd7, 1'b1, 13'h1FFF, 0, 0, 0);    // jump to top of PC space
    run_instr(3'd6, 1'b0, '0, 0, 1, 0);          // ST, PC wraps to 0

    run_fault();
    run_instr(3'd0, 1'b0, '0, 0, 0, 0);
    run_mid_mem_reset();
    run_instr(3'd4, 1'b0, '0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), PW'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
